// File: rtl/nes_load_pkg.sv
// Shared types and constants for the iNES game loader: FSM states, header magic, section lengths.
package nes_load_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RELOAD,
    ST_HEADER,
    ST_TRAINER,
    ST_PRG,
    ST_CHR,
    ST_DRAIN,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] INES_MAGIC0 = 8'h4E;
  localparam logic [7:0] INES_MAGIC1 = 8'h45;
  localparam logic [7:0] INES_MAGIC2 = 8'h53;
  localparam logic [7:0] INES_MAGIC3 = 8'h1A;

  localparam int PRG_UNIT    = 16384;
  localparam int CHR_UNIT    = 8192;
  localparam int TRAINER_LEN = 512;
  localparam int HEADER_LEN  = 16;

  function automatic logic magic_ok(input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2, input logic [7:0] b3);
    return (b0 == INES_MAGIC0) && (b1 == INES_MAGIC1) &&
           (b2 == INES_MAGIC2) && (b3 == INES_MAGIC3);
  endfunction

endpackage

// File: rtl/ines_header_parser.sv
// Captures the 16-byte iNES header, flags the last byte and its validity, and registers
// the decoded fields when that last byte is accepted.
module ines_header_parser
  import nes_load_pkg::*;
#(
  parameter int PRG_MAX_UNITS = 32,
  parameter int CHR_MAX_UNITS = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_clear,
  input  logic [7:0] i_byte,
  input  logic       i_valid,
  output logic       o_last,
  output logic       o_ok,
  output logic       o_trainer,
  output logic [7:0] o_prg_units,
  output logic [7:0] o_chr_units,
  output logic [7:0] o_mapper,
  output logic       o_mirroring
);

  logic [3:0] r_idx;
  logic [7:0] r_hdr [8];
  logic [7:0] r_prg_units;
  logic [7:0] r_chr_units;
  logic [7:0] r_mapper;
  logic       r_mirroring;

  // Only bytes 0..7 carry fields we use; bytes 8..15 are counted but not stored.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_idx       <= '0;
      for (int i = 0; i < 8; i++) r_hdr[i] <= '0;
      r_prg_units <= '0;
      r_chr_units <= '0;
      r_mapper    <= '0;
      r_mirroring <= 1'b0;
    end else if (i_valid) begin
      r_idx <= r_idx + 4'd1;
      if (!r_idx[3]) r_hdr[r_idx[2:0]] <= i_byte;
      if (o_last) begin
        r_prg_units <= r_hdr[4];
        r_chr_units <= r_hdr[5];
        r_mapper    <= {r_hdr[7][7:4], r_hdr[6][7:4]};
        r_mirroring <= r_hdr[6][0];
      end
    end
  end

  assign o_last    = i_valid && (r_idx == 4'(HEADER_LEN - 1));
  assign o_ok      = magic_ok(r_hdr[0], r_hdr[1], r_hdr[2], r_hdr[3]) &&
                     (r_hdr[4] != 8'd0) &&
                     (r_hdr[4] <= 8'(PRG_MAX_UNITS)) &&
                     (r_hdr[5] <= 8'(CHR_MAX_UNITS));
  assign o_trainer = r_hdr[6][2];

  assign o_prg_units = r_prg_units;
  assign o_chr_units = r_chr_units;
  assign o_mapper    = r_mapper;
  assign o_mirroring = r_mirroring;

endmodule

// File: rtl/rom_load_sequencer.sv
// Streams a game image from flash: header parse, optional trainer skip, then PRG and CHR
// bytes to a flat write port, holding the NES core in reset until the load completes.
module rom_load_sequencer
  import nes_load_pkg::*;
#(
  parameter int          PRG_MAX_UNITS = 32,
  parameter int          CHR_MAX_UNITS = 32,
  parameter logic [19:0] CHR_BASE      = 20'h80000,
  parameter bit          AUTOLOAD      = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        select_req,
  input  logic [3:0]  select_index,
  output logic        loader_reload,
  output logic [3:0]  loader_index,
  input  logic [7:0]  loader_data,
  input  logic        loader_valid,
  output logic        mem_we,
  output logic [19:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        nes_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  prg_units,
  output logic [7:0]  chr_units,
  output logic [7:0]  mapper,
  output logic        mirroring
);

  state_t      r_state;
  state_t      w_next;
  logic        r_boot;
  logic [3:0]  r_index;
  logic [19:0] r_cnt;
  logic        r_we;
  logic [19:0] r_addr;
  logic [7:0]  r_data;

  logic        w_hdr_vld;
  logic        w_hdr_last;
  logic        w_hdr_ok;
  logic        w_hdr_trainer;
  logic        w_wr;
  logic        w_cnt_en;
  logic [19:0] w_prg_last;
  logic [19:0] w_chr_last;

  assign w_prg_last = 20'(prg_units) * 20'(PRG_UNIT) - 20'd1;
  assign w_chr_last = 20'(chr_units) * 20'(CHR_UNIT) - 20'd1;
  assign w_hdr_vld  = loader_valid && !select_req && (r_state == ST_HEADER);

  ines_header_parser #(
    .PRG_MAX_UNITS (PRG_MAX_UNITS),
    .CHR_MAX_UNITS (CHR_MAX_UNITS)
  ) u_hdr (
    .clock       (clock),
    .reset       (reset),
    .i_clear     (r_state == ST_RELOAD),
    .i_byte      (loader_data),
    .i_valid     (w_hdr_vld),
    .o_last      (w_hdr_last),
    .o_ok        (w_hdr_ok),
    .o_trainer   (w_hdr_trainer),
    .o_prg_units (prg_units),
    .o_chr_units (chr_units),
    .o_mapper    (mapper),
    .o_mirroring (mirroring)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_wr     = 1'b0;
    w_cnt_en = 1'b0;
    unique case (r_state)
      ST_IDLE:   if (r_boot) w_next = ST_RELOAD;
      ST_RELOAD: w_next = ST_HEADER;
      ST_HEADER: begin
        if (w_hdr_last) begin
          if (!w_hdr_ok)          w_next = ST_ERROR;
          else if (w_hdr_trainer) w_next = ST_TRAINER;
          else                    w_next = ST_PRG;
        end
      end
      ST_TRAINER: begin
        if (loader_valid) begin
          w_cnt_en = 1'b1;
          if (r_cnt == 20'(TRAINER_LEN - 1)) w_next = ST_PRG;
        end
      end
      ST_PRG: begin
        if (loader_valid) begin
          w_wr     = 1'b1;
          w_cnt_en = 1'b1;
          if (r_cnt == w_prg_last) w_next = (chr_units == 8'd0) ? ST_DRAIN : ST_CHR;
        end
      end
      ST_CHR: begin
        if (loader_valid) begin
          w_wr     = 1'b1;
          w_cnt_en = 1'b1;
          if (r_cnt == w_chr_last) w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: w_next = ST_DONE;
      ST_DONE:  w_next = ST_DONE;
      ST_ERROR: w_next = ST_ERROR;
      default:  w_next = ST_IDLE;
    endcase
    // A new selection wins over everything, including a byte arriving this cycle.
    if (select_req) begin
      w_next   = ST_RELOAD;
      w_wr     = 1'b0;
      w_cnt_en = 1'b0;
    end
  end

  // The counter restarts on every state change, so each section counts from zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_boot  <= AUTOLOAD;
      r_index <= '0;
      r_cnt   <= '0;
    end else begin
      r_boot <= 1'b0;
      if (select_req) r_index <= select_index;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_cnt_en)     r_cnt <= r_cnt + 20'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_addr <= (r_state == ST_CHR) ? (CHR_BASE + r_cnt) : r_cnt;
        r_data <= loader_data;
      end
    end
  end

  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_data      = r_data;
  assign loader_reload = (r_state == ST_RELOAD);
  assign loader_index  = r_index;
  assign nes_reset     = (r_state != ST_DONE);
  assign busy          = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERROR);
  assign done          = (r_state == ST_DONE);
  assign error         = (r_state == ST_ERROR);

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Bench for rom_load_sequencer: random payloads checked against a stream-level iNES model,
// a table of header cases, and hand sequences for abort and mid-load reset.
module tb_rom_load_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        select_req = 1'b0;
  logic [3:0]  select_index = '0;
  logic [7:0]  loader_data = '0;
  logic        loader_valid = 1'b0;
  logic        loader_reload;
  logic [3:0]  loader_index;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [7:0]  mem_data;
  logic        nes_reset, busy, done, error, mirroring;
  logic [7:0]  prg_units, chr_units, mapper;

  rom_load_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .select_req    (select_req),
    .select_index  (select_index),
    .loader_reload (loader_reload),
    .loader_index  (loader_index),
    .loader_data   (loader_data),
    .loader_valid  (loader_valid),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .nes_reset     (nes_reset),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .prg_units     (prg_units),
    .chr_units     (chr_units),
    .mapper        (mapper),
    .mirroring     (mirroring)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: position in the stream since the last reload decides where a byte lands.
  logic [7:0]  m_hdr [16];
  int          m_idx, m_skip, m_prg_len, m_chr_len;
  bit          m_ok;
  logic [27:0] exp_q [$];

  function automatic void model_restart();
    m_idx = 0; m_ok = 1'b0; m_skip = 0; m_prg_len = 0; m_chr_len = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int j;
    if (m_idx < 16) begin
      m_hdr[m_idx] = b;
      if (m_idx == 15) begin
        m_ok = (m_hdr[0] == 8'h4E) && (m_hdr[1] == 8'h45) && (m_hdr[2] == 8'h53) &&
               (m_hdr[3] == 8'h1A) && (m_hdr[4] >= 1) && (m_hdr[4] <= 32) && (m_hdr[5] <= 32);
        m_skip    = m_hdr[6][2] ? 512 : 0;
        m_prg_len = int'(m_hdr[4]) * 16384;
        m_chr_len = int'(m_hdr[5]) * 8192;
      end
    end else if (m_ok) begin
      j = m_idx - 16 - m_skip;
      if (j >= 0 && j < m_prg_len)
        exp_q.push_back({20'(j), b});
      else if (j >= m_prg_len && j < m_prg_len + m_chr_len)
        exp_q.push_back({20'(32'h80000 + j - m_prg_len), b});
    end
    m_idx++;
  endfunction

  int         n_reload = 0;
  int         n_writes = 0;
  bit         done_seen = 1'b0;
  logic [27:0] e;

  always @(negedge clock) begin
    if (loader_reload) n_reload++;
    if (done) done_seen = 1'b1;
    if (mem_we) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: addr %0h data %0h with none expected", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr_data", {4'h0, mem_addr, mem_data}, {4'h0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    if (gap && $urandom_range(15) == 0) tick();
    loader_data  = b;
    loader_valid = 1'b1;
    model_byte(b);
    tick();
    loader_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] m3, input logic [7:0] p, input logic [7:0] c,
                          input logic [7:0] b6, input logic [7:0] b7, input bit gap);
    send(8'h4E, gap); send(8'h45, gap); send(8'h53, gap); send(m3, gap);
    send(p, gap); send(c, gap); send(b6, gap); send(b7, gap);
    for (int i = 8; i < 16; i++) send(8'($urandom), gap);
  endtask

  task automatic send_payload(input int n, input bit gap);
    for (int i = 0; i < n; i++) send(8'($urandom), gap);
  endtask

  task automatic do_select(input logic [3:0] idx);
    select_req   = 1'b1;
    select_index = idx;
    tick();
    select_req = 1'b0;
    model_restart();
    chk("select_reload", loader_reload, 1);
    chk("select_index", loader_index, idx);
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_flags"}, {nes_reset, busy, done, error, mem_we, loader_reload, mirroring}, 7'b1000000);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data"}, mem_data, 0);
    chk({tag, "_index"}, loader_index, 0);
    chk({tag, "_fields"}, {prg_units, chr_units, mapper}, 0);
  endtask

  typedef struct {
    logic [7:0] m3, p, c, b6, b7;
    bit         exp_err;
    logic [7:0] exp_map;
    bit         exp_mir;
  } vec_t;

  vec_t vt [6];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{8'h00, 8'd1,  8'd1,  8'h00, 8'h00, 1'b1, 8'h00, 1'b0};  // bad magic
    vt[1] = '{8'h1A, 8'd33, 8'd0,  8'h11, 8'h40, 1'b1, 8'h41, 1'b1};  // PRG too large
    vt[2] = '{8'h1A, 8'd0,  8'd1,  8'h00, 8'h00, 1'b1, 8'h00, 1'b0};  // zero PRG
    vt[3] = '{8'h1A, 8'd1,  8'd33, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0};  // CHR too large
    vt[4] = '{8'h1A, 8'd32, 8'd32, 8'h01, 8'hA0, 1'b0, 8'hA0, 1'b1};  // both at max
    vt[5] = '{8'h1A, 8'd1,  8'd0,  8'hF5, 8'h30, 1'b0, 8'h3F, 1'b1};  // trainer, mapper 0x3F

    model_restart();
    tick();
    tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();
    chk("boot_reload", loader_reload, 1);
    chk("boot_index", loader_index, 0);
    chk("boot_nes_reset_busy", {nes_reset, busy}, 2'b11);
    tick();

    // 2 PRG / 1 CHR, back-to-back bytes.
    n_writes = 0;
    send_hdr(8'h1A, 8'd2, 8'd1, 8'h00, 8'h00, 1'b0);
    send_payload(40960, 1'b0);
    chk("t1_done_not_early", done, 0);
    tick();
    chk("t1_done", {done, nes_reset, busy, error}, 4'b1000);
    chk("t1_fields", {prg_units, chr_units, mapper}, {8'd2, 8'd1, 8'd0});
    chk("t1_write_count", n_writes, 40960);
    send_payload(5, 1'b0);
    tick();
    chk("t1_still_done", done, 1);

    // Trainer skip, 1 PRG / CHR RAM, random gaps.
    n_writes = 0;
    do_select(4'd3);
    send_hdr(8'h1A, 8'd1, 8'd0, 8'h14, 8'h00, 1'b1);
    send_payload(512 + 16384, 1'b1);
    tick();
    chk("t2_done", {done, nes_reset}, 2'b10);
    chk("t2_fields", {prg_units, chr_units, mapper, 7'd0, mirroring}, {8'd1, 8'd0, 8'd1, 8'd0});
    chk("t2_write_count", n_writes, 16384);

    // Header validation table.
    for (int i = 0; i < 6; i++) begin
      do_select(4'(i));
      send_hdr(vt[i].m3, vt[i].p, vt[i].c, vt[i].b6, vt[i].b7, 1'b1);
      chk($sformatf("vec%0d_error", i), error, vt[i].exp_err);
      chk($sformatf("vec%0d_busy", i), busy, !vt[i].exp_err);
      chk($sformatf("vec%0d_fields", i), {prg_units, chr_units, mapper},
          {vt[i].p, vt[i].c, vt[i].exp_map});
      chk($sformatf("vec%0d_mirror", i), mirroring, vt[i].exp_mir);
      send_payload(8, 1'b0);
      tick();
      chk($sformatf("vec%0d_after", i), {error, done, nes_reset}, {vt[i].exp_err, 1'b0, 1'b1});
    end

    // Abort mid-PRG with a new selection colliding with a valid byte.
    do_select(4'd7);
    send_hdr(8'h1A, 8'd1, 8'd1, 8'h00, 8'h00, 1'b1);
    done_seen = 1'b0;
    send_payload(1000, 1'b1);
    n_reload     = 0;
    select_req   = 1'b1;
    select_index = 4'd5;
    loader_valid = 1'b1;
    loader_data  = 8'hAA;
    tick();
    select_req   = 1'b0;
    loader_valid = 1'b0;
    model_restart();
    chk("abort_reload", loader_reload, 1);
    chk("abort_index", loader_index, 5);
    tick();
    send_hdr(8'h1A, 8'd1, 8'd1, 8'h01, 8'h20, 1'b1);
    chk("abort_new_hdr", {prg_units, chr_units, mapper, 7'd0, mirroring},
        {8'd1, 8'd1, 8'h20, 8'd1});
    chk("abort_error", error, 0);
    chk("abort_reload_count", n_reload, 1);
    chk("abort_done_seen", done_seen, 0);

    // Reset in the middle of CHR.
    send_payload(16384 + 100, 1'b0);
    chk("midchr_busy", busy, 1);
    reset = 1'b1;
    tick();
    chk_reset_vals("midchr");
    chk("queue_drained", exp_q.size(), 0);
    reset = 1'b0;
    tick();
    chk("post_reset_reload", loader_reload, 1);
    chk("post_reset_index", loader_index, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
